// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM encoding and PC defaults.
package pc_sequencer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEF  = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Handshake/bus bundle between ID-stage branch resolution, IF stage and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start_i;
  logic             stall_i;
  logic             branch_i;
  logic             equal_i;
  logic [31:0]      branch_addr_i;
  logic             jump_i;
  logic [31:0]      jump_addr_i;
  logic             imem_ready_i;
  logic [31:0]      pc_o;
  logic             imem_req_o;
  logic             ifid_write_o;
  logic             if_flush_o;
  logic             taken_o;
  logic [CNT_W-1:0] taken_cnt_o;

  modport master (
    output start_i, stall_i, branch_i, equal_i, branch_addr_i,
           jump_i, jump_addr_i, imem_ready_i,
    input  pc_o, imem_req_o, ifid_write_o, if_flush_o, taken_o, taken_cnt_o
  );

  modport slave (
    input  start_i, stall_i, branch_i, equal_i, branch_addr_i,
           jump_i, jump_addr_i, imem_ready_i,
    output pc_o, imem_req_o, ifid_write_o, if_flush_o, taken_o, taken_cnt_o
  );
endinterface

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC datapath: redirect target select with word alignment, and PC+step.
module next_pc_mux #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  output logic [31:0] tgt,
  output logic [31:0] pc_seq
);

  // Jump wins over a simultaneously taken branch; targets are forced word-aligned.
  always_comb begin
    tgt      = jump ? jump_addr : branch_addr;
    tgt[1:0] = 2'b00;
  end

  assign pc_seq = pc + 32'(PC_STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential stepping, branch/jump redirect, and deferred redirect across imem misses.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_sequencer_if.slave  bus
);

  state_t           state;
  logic [31:0]      pc;
  logic             pend_v;
  logic [31:0]      pend_pc;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      tgt;
  logic [31:0]      pc_seq;
  logic             fetch;
  logic             redir;
  logic             taken;

  next_pc_mux #(.PC_STEP(PC_STEP)) u_next_pc_mux (
    .pc          (pc),
    .jump        (bus.jump_i),
    .branch_addr (bus.branch_addr_i),
    .jump_addr   (bus.jump_addr_i),
    .tgt         (tgt),
    .pc_seq      (pc_seq)
  );

  assign fetch = (state == FETCH);
  assign redir = bus.jump_i | (bus.branch_i & bus.equal_i);
  assign taken = fetch & ~bus.stall_i & bus.branch_i & bus.equal_i & ~bus.jump_i;

  always_comb begin
    bus.imem_req_o   = 1'b0;
    bus.ifid_write_o = 1'b0;
    bus.if_flush_o   = 1'b0;
    if (fetch) begin
      bus.imem_req_o = 1'b1;
      if (!bus.stall_i) begin
        bus.ifid_write_o = 1'b1;
        // A miss feeds a bubble; a completed fetch is dropped if any redirect applies to it.
        bus.if_flush_o   = ~bus.imem_ready_i | redir | pend_v;
      end
    end
  end

  assign bus.taken_o     = taken;
  assign bus.pc_o        = pc;
  assign bus.taken_cnt_o = cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) state <= FETCH;
        FETCH: begin
          if (!bus.stall_i) begin
            if (bus.imem_ready_i) begin
              pend_v <= 1'b0;
              if (redir)       pc <= tgt;
              else if (pend_v) pc <= pend_pc;
              else             pc <= pc_seq;
            end else if (redir) begin
              pend_v  <= 1'b1;
              pend_pc <= tgt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              cnt <= '0;
    else if (taken && !(&cnt)) cnt <= cnt + 1'b1;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations plus randomized traffic.
module tb_pc_sequencer;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: has start been seen, current PC, outstanding redirect, taken count.
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pv;
  logic [31:0] m_ppc;
  int unsigned m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_pv = 0; m_ppc = 32'h0; m_cnt = 0;
  endtask

  // Compare every output against the rules for this cycle, then advance the model to the next edge.
  task automatic compare_and_advance();
    logic [31:0] tgt;
    bit redir, e_req, e_wr, e_fl, e_tk;
    redir = bus.jump_i || (bus.branch_i && bus.equal_i);
    tgt   = bus.jump_i ? bus.jump_addr_i : bus.branch_addr_i;
    tgt   = {tgt[31:2], 2'b00};
    e_req = m_run;
    e_wr  = m_run && !bus.stall_i;
    e_fl  = m_run && !bus.stall_i && (!bus.imem_ready_i || redir || m_pv);
    e_tk  = m_run && !bus.stall_i && bus.branch_i && bus.equal_i && !bus.jump_i;
    check("pc_o",         bus.pc_o, m_pc);
    check("imem_req_o",   32'(bus.imem_req_o), 32'(e_req));
    check("ifid_write_o", 32'(bus.ifid_write_o), 32'(e_wr));
    check("if_flush_o",   32'(bus.if_flush_o), 32'(e_fl));
    check("taken_o",      32'(bus.taken_o), 32'(e_tk));
    check("taken_cnt_o",  32'(bus.taken_cnt_o), m_cnt);
    if (!m_run) begin
      if (bus.start_i) m_run = 1;
    end else begin
      if (e_tk && m_cnt < CNT_MAX) m_cnt++;
      if (!bus.stall_i) begin
        if (bus.imem_ready_i) begin
          if (redir)     m_pc = tgt;
          else if (m_pv) m_pc = m_ppc;
          else           m_pc = m_pc + 32'd4;
          m_pv = 0;
        end else if (redir) begin
          m_pv = 1; m_ppc = tgt;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_and_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst pc_o",         bus.pc_o, 32'h0);
    check("rst imem_req_o",   32'(bus.imem_req_o), 32'h0);
    check("rst ifid_write_o", 32'(bus.ifid_write_o), 32'h0);
    check("rst if_flush_o",   32'(bus.if_flush_o), 32'h0);
    check("rst taken_o",      32'(bus.taken_o), 32'h0);
    check("rst taken_cnt_o",  32'(bus.taken_cnt_o), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start_i = 0; bus.stall_i = 0; bus.branch_i = 0; bus.equal_i = 0;
    bus.branch_addr_i = '0; bus.jump_i = 0; bus.jump_addr_i = '0; bus.imem_ready_i = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    do_reset();

    // Start and straight-line fetch.
    bus.start_i = 1; settle();
    check("idle pc_o", bus.pc_o, 32'h0);
    check("idle imem_req_o", 32'(bus.imem_req_o), 32'h0);
    step();
    bus.start_i = 0; bus.imem_ready_i = 1; settle();
    check("seq pc0", bus.pc_o, 32'h0);
    check("seq flush", 32'(bus.if_flush_o), 32'h0);
    check("seq write", 32'(bus.ifid_write_o), 32'h1);
    step(); check("seq pc4", bus.pc_o, 32'h4);
    step(); check("seq pc8", bus.pc_o, 32'h8);

    // Taken branch at PC 8, first stalled then accepted.
    bus.stall_i = 1; bus.branch_i = 1; bus.equal_i = 1; bus.branch_addr_i = 32'h40; settle();
    check("stall write", 32'(bus.ifid_write_o), 32'h0);
    check("stall taken", 32'(bus.taken_o), 32'h0);
    check("stall flush", 32'(bus.if_flush_o), 32'h0);
    step(); check("stall pc hold", bus.pc_o, 32'h8);
    bus.stall_i = 0; settle();
    check("br taken", 32'(bus.taken_o), 32'h1);
    check("br flush", 32'(bus.if_flush_o), 32'h1);
    step();
    check("br pc", bus.pc_o, 32'h40);
    check("br cnt", 32'(bus.taken_cnt_o), 32'h1);
    bus.branch_i = 0; bus.equal_i = 0;

    // Jump during a 3-cycle miss is held and applied when the fetch completes.
    bus.imem_ready_i = 0; bus.jump_i = 1; bus.jump_addr_i = 32'h100; settle();
    check("miss1 flush", 32'(bus.if_flush_o), 32'h1);
    step(); bus.jump_i = 0; settle();
    check("miss2 flush", 32'(bus.if_flush_o), 32'h1);
    step(); settle();
    check("miss3 flush", 32'(bus.if_flush_o), 32'h1);
    check("miss pc hold", bus.pc_o, 32'h40);
    step();
    bus.imem_ready_i = 1; settle();
    check("pend flush", 32'(bus.if_flush_o), 32'h1);
    check("pend write", 32'(bus.ifid_write_o), 32'h1);
    step(); check("pend pc", bus.pc_o, 32'h100);

    // Jump beats a simultaneously taken branch.
    bus.jump_i = 1; bus.jump_addr_i = 32'h80;
    bus.branch_i = 1; bus.equal_i = 1; bus.branch_addr_i = 32'h40; settle();
    check("jmp+br taken", 32'(bus.taken_o), 32'h0);
    step();
    check("jmp+br pc", bus.pc_o, 32'h80);
    check("jmp+br cnt", 32'(bus.taken_cnt_o), 32'h1);
    bus.branch_i = 0; bus.equal_i = 0;

    // Reset while a redirect is pending.
    bus.imem_ready_i = 0; bus.jump_addr_i = 32'h200;
    step();
    bus.jump_i = 0;
    #2;
    do_reset();
    bus.start_i = 1; step(); bus.start_i = 0;

    // Aligned jump near the top of memory, then sequential wrap.
    bus.imem_ready_i = 1; bus.jump_i = 1; bus.jump_addr_i = 32'hFFFF_FFFF;
    step();
    bus.jump_i = 0; settle();
    check("top pc", bus.pc_o, 32'hFFFF_FFFC);
    step(); check("wrap pc", bus.pc_o, 32'h0);

    // Counter saturation.
    bus.branch_i = 1; bus.equal_i = 1;
    for (int i = 0; i < CNT_MAX; i++) begin
      bus.branch_addr_i = $urandom;
      step();
    end
    check("cnt full", 32'(bus.taken_cnt_o), 32'h0000_FFFF);
    for (int i = 0; i < 4; i++) step();
    check("cnt sat", 32'(bus.taken_cnt_o), 32'h0000_FFFF);
    clear_inputs();

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        bus.start_i = 1; step();
      end
      bus.start_i       = ($urandom_range(0, 3) == 0);
      bus.stall_i       = ($urandom_range(0, 5) == 0);
      bus.imem_ready_i  = ($urandom_range(0, 2) != 0);
      bus.branch_i      = ($urandom_range(0, 2) == 0);
      bus.equal_i       = ($urandom_range(0, 1) == 0);
      bus.jump_i        = ($urandom_range(0, 5) == 0);
      bus.branch_addr_i = $urandom;
      bus.jump_addr_i   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
